// File: rtl/key_led_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_led_mode_ctrl
// Brief    : Key synchroniser/debouncer, short/long press classifier and
//            2-bit LED mode sequencer with blink patterns.
//            Optional idle auto-off: define KEY_LED_AUTO_OFF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module key_led_mode_ctrl #(
  parameter int unsigned CNT_DEB   = 250,
  parameter int unsigned CNT_LONG  = 1000,
  parameter int unsigned CNT_BLINK = 50,
  parameter int unsigned CNT_IDLE  = 5000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_in,
  output logic [1:0] led,
  output logic [1:0] mode,
  output logic       press_short,
  output logic       press_long
);

  localparam int unsigned c_DEB_W   = $clog2(CNT_DEB);
  localparam int unsigned c_LONG_W  = $clog2(CNT_LONG);
  localparam int unsigned c_BLINK_W = $clog2(CNT_BLINK);

  localparam logic [c_DEB_W-1:0]   c_DEB_LAST   = c_DEB_W'(CNT_DEB - 1);
  localparam logic [c_LONG_W-1:0]  c_LONG_LAST  = c_LONG_W'(CNT_LONG - 1);
  localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(CNT_BLINK - 1);

  if (CNT_DEB < 2 || CNT_LONG <= CNT_DEB || CNT_BLINK < 2 || CNT_IDLE < 2) begin : g_param_check
    $error("key_led_mode_ctrl: illegal counter parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_HELD  = 2'd2
  } state_t;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_key_stb;
  logic [c_DEB_W-1:0]   r_cnt_deb;
  state_t               r_state;
  logic [c_LONG_W-1:0]  r_cnt_press;
  logic                 r_press_short;
  logic                 r_press_long;
  logic [1:0]           r_mode;
  logic [c_BLINK_W-1:0] r_cnt_blink;
  logic                 r_blink;
  logic [1:0]           r_led;
  logic                 w_auto_off;
  logic                 w_mode_upd;
  logic [1:0]           w_mode_nxt;

  // Synchroniser and debounce; flops idle high to match the released key.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_key_stb <= 1'b1;
      r_cnt_deb <= '0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_key_stb) begin
        r_cnt_deb <= '0;
      end else if (r_cnt_deb == c_DEB_LAST) begin
        r_key_stb <= r_sync2;
        r_cnt_deb <= '0;
      end else begin
        r_cnt_deb <= r_cnt_deb + 1'b1;
      end
    end
  end

  // IDLE is only ever entered with key_stb high, so a low level there is a fresh press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= S_IDLE;
      r_cnt_press   <= '0;
      r_press_short <= 1'b0;
      r_press_long  <= 1'b0;
    end else begin
      r_press_short <= 1'b0;
      r_press_long  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_key_stb) begin
            r_state     <= S_PRESS;
            r_cnt_press <= '0;
          end
        end
        S_PRESS: begin
          if (r_key_stb) begin
            r_press_short <= 1'b1;
            r_state       <= S_IDLE;
          end else if (r_cnt_press == c_LONG_LAST) begin
            r_press_long <= 1'b1;
            r_state      <= S_HELD;
          end else begin
            r_cnt_press <= r_cnt_press + 1'b1;
          end
        end
        S_HELD: begin
          if (r_key_stb) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef KEY_LED_AUTO_OFF_EN
  localparam int unsigned           c_IDLE_W    = $clog2(CNT_IDLE);
  localparam logic [c_IDLE_W-1:0]   c_IDLE_LAST = c_IDLE_W'(CNT_IDLE - 1);

  logic [c_IDLE_W-1:0] r_cnt_idle;

  // A press arriving on the timeout cycle wins over the auto-off.
  assign w_auto_off = (r_mode != 2'd0) && !r_press_short && !r_press_long &&
                      (r_cnt_idle == c_IDLE_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt_idle <= '0;
    end else if (r_press_short || r_press_long || (r_mode == 2'd0) || w_auto_off) begin
      r_cnt_idle <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt_idle <= r_cnt_idle + 1'b1;
    end
  end
`else
  assign w_auto_off = 1'b0;
`endif

  assign w_mode_upd = r_press_short | r_press_long | w_auto_off;
  assign w_mode_nxt = r_press_short ? (r_mode + 2'd1) : 2'd0;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_mode      <= 2'd0;
      r_cnt_blink <= '0;
      r_blink     <= 1'b0;
      r_led       <= 2'b00;
    end else begin
      if (w_mode_upd) begin
        r_mode      <= w_mode_nxt;
        r_cnt_blink <= '0;
        r_blink     <= 1'b0;
      end else if (r_cnt_blink == c_BLINK_LAST) begin
        r_cnt_blink <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_cnt_blink <= r_cnt_blink + 1'b1;
      end

      case (r_mode)
        2'd0:    r_led <= 2'b00;
        2'd1:    r_led <= 2'b01;
        2'd2:    r_led <= {r_blink, ~r_blink};
        default: r_led <= {r_blink, r_blink};
      endcase
    end
  end

  assign led         = r_led;
  assign mode        = r_mode;
  assign press_short = r_press_short;
  assign press_long  = r_press_long;

endmodule
`default_nettype wire

// File: tb/tb_key_led_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_led_mode_ctrl
// Brief    : Self-checking bench for key_led_mode_ctrl against a timestamp-based
//            reference model; honours KEY_LED_AUTO_OFF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_led_mode_ctrl;

  localparam int DEB   = 20;
  localparam int LONG  = 200;
  localparam int BLINK = 10;
  localparam int IDLE  = 500;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       key_in    = 1'b1;
  logic [1:0] led;
  logic [1:0] mode;
  logic       press_short;
  logic       press_long;

  key_led_mode_ctrl #(
    .CNT_DEB   (DEB),
    .CNT_LONG  (LONG),
    .CNT_BLINK (BLINK),
    .CNT_IDLE  (IDLE)
  ) u_dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_in      (key_in),
    .led         (led),
    .mode        (mode),
    .press_short (press_short),
    .press_long  (press_long)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_cyc = 0;
  bit m_k1 = 1'b1, m_k2 = 1'b1;
  bit m_win[$];
  bit m_stb = 1'b1;
  bit m_pressing = 1'b0, m_held = 1'b0;
  int m_press_t = 0;
  bit m_short = 1'b0, m_long = 1'b0;
  int m_mode = 0, m_mode_t = 0, m_idle = 0, m_led = 0;

  function automatic int blink_at(input int c, input int t0);
    return ((c - t0) / BLINK) % 2;
  endfunction

  function automatic int led_map(input int md, input int bl);
    case (md)
      0:       return 0;
      1:       return 1;
      2:       return (bl != 0) ? 2 : 1;
      default: return (bl != 0) ? 3 : 0;
    endcase
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_k1 = 1'b1; m_k2 = 1'b1;
    m_win.delete();
    for (int i = 0; i < DEB; i++) m_win.push_back(1'b1);
    m_stb = 1'b1; m_pressing = 1'b0; m_held = 1'b0; m_press_t = 0;
    m_short = 1'b0; m_long = 1'b0;
    m_mode = 0; m_mode_t = 0; m_idle = 0; m_led = 0;
  endtask

  task automatic model_step();
    bit o_sync     = m_k2;
    bit o_stb      = m_stb;
    bit o_short    = m_short;
    bit o_long     = m_long;
    bit o_idle_fsm = !m_pressing && !m_held;
    int o_mode     = m_mode;
    int o_blink    = blink_at(m_cyc, m_mode_t);
    bit flip       = 1'b1;
    bit upd        = 1'b0;
    m_cyc++;
    m_k2 = m_k1;
    m_k1 = key_in;
    // the level is accepted once the last DEB synchronised samples all disagree with it
    m_win.push_back(o_sync);
    void'(m_win.pop_front());
    foreach (m_win[i]) if (m_win[i] == o_stb) flip = 1'b0;
    if (flip) m_stb = o_sync;

    m_short = 1'b0;
    m_long  = 1'b0;
    if (m_pressing) begin
      if (o_stb) begin
        m_short = 1'b1; m_pressing = 1'b0;
      end else if (m_cyc - m_press_t == LONG) begin
        m_long = 1'b1; m_pressing = 1'b0; m_held = 1'b1;
      end
    end else if (m_held) begin
      if (o_stb) m_held = 1'b0;
    end else if (!o_stb) begin
      m_pressing = 1'b1; m_press_t = m_cyc;
    end

    if (o_short) begin
      m_mode = (o_mode + 1) % 4; upd = 1'b1;
    end else if (o_long) begin
      m_mode = 0; upd = 1'b1;
    end
`ifdef KEY_LED_AUTO_OFF_EN
    if (o_short || o_long || o_mode == 0) m_idle = 0;
    else if (m_idle == IDLE - 1) begin
      m_mode = 0; upd = 1'b1; m_idle = 0;
    end else if (o_idle_fsm) m_idle++;
`else
    if (o_idle_fsm) m_idle = 0;
`endif
    if (upd) m_mode_t = m_cyc;
    m_led = led_map(o_mode, o_blink);
  endtask

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) model_reset();
    else            model_step();
  end

  // ---------------- monitor ----------------
  int tb_cyc  = 0;
  int n_short = 0;
  int n_long  = 0;
  int t_long  = 0;

  always @(posedge sys_clk) tb_cyc++;

  always @(negedge sys_clk) begin
    if (press_short === 1'b1) n_short++;
    if (press_long === 1'b1) begin
      n_long++;
      t_long = tb_cyc;
    end
    check_eq("cyc_led", {30'd0, led}, m_led);
    check_eq("cyc_mode", {30'd0, mode}, m_mode);
    check_eq("cyc_press_short", {31'd0, press_short}, {31'd0, m_short});
    check_eq("cyc_press_long", {31'd0, press_long}, {31'd0, m_long});
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      #1;
    end
  endtask

  task automatic bounce(input int n);
    for (int i = 0; i < n; i++) begin
      key_in = 1'($urandom_range(0, 1));
      step(1);
    end
  endtask

  task automatic do_reset(input string tag);
    sys_rst_n = 1'b0;
    step(3);
    check_eq({tag, "_led"}, {30'd0, led}, 0);
    check_eq({tag, "_mode"}, {30'd0, mode}, 0);
    check_eq({tag, "_pulses"}, {30'd0, press_short, press_long}, 0);
    sys_rst_n = 1'b1;
  endtask

  // Waits (bounded) for mode to reach exp_mode, then checks the LED one cycle later.
  task automatic expect_mode(input string tag, input int exp_mode, input int exp_led, input int budget);
    int k = 0;
    while (mode !== 2'(exp_mode) && k < budget) begin
      step(1);
      k++;
    end
    check_eq(tag, {30'd0, mode}, exp_mode);
    step(1);
    check_eq({tag, "_led"}, {30'd0, led}, exp_led);
  endtask

  task automatic clean_short(input string tag, input int exp_mode, input int exp_led);
    key_in = 1'b0;
    step(60);
    key_in = 1'b1;
    expect_mode(tag, exp_mode, exp_led, 100);
    step(100);
  endtask

  int base_s, base_l, t_fall, lat;

  initial begin
    step(3);
    check_eq("rst_led", {30'd0, led}, 0);
    check_eq("rst_mode", {30'd0, mode}, 0);
    check_eq("rst_pulses", {30'd0, press_short, press_long}, 0);
    sys_rst_n = 1'b1;

    // idle key: nothing happens
    step(1000);
    check_eq("s1_short", n_short, 0);
    check_eq("s1_long", n_long, 0);
    check_eq("s1_mode", {30'd0, mode}, 0);
    check_eq("s1_led", {30'd0, led}, 0);

    // bouncy short press
    base_s = n_short;
    bounce(15);
    key_in = 1'b0;
    step(60);
    bounce(15);
    key_in = 1'b1;
    expect_mode("s2_mode", 1, 1, 100);
    step(100);
    check_eq("s2_short_count", n_short - base_s, 1);

    // four clean presses from reset, then two more to reach mode 2
    do_reset("s3_rst");
    clean_short("s3_m1", 1, 1);
    clean_short("s3_m2", 2, 1);
    clean_short("s3_m3", 3, 0);
    clean_short("s3_m0", 0, 0);
    clean_short("s4_pre1", 1, 1);
    clean_short("s4_pre2", 2, 1);

    // long press from mode 2
    base_s = n_short;
    base_l = n_long;
    key_in = 1'b0;
    t_fall = tb_cyc;
    expect_mode("s4_mode", 0, 0, 300);
    lat = t_long - t_fall;
    check_eq("s4_long_latency", (lat >= 221 && lat <= 223) ? 222 : lat, 222);
    step(170);
    key_in = 1'b1;
    step(100);
    check_eq("s4_long_count", n_long - base_l, 1);
    check_eq("s4_no_short", n_short - base_s, 0);

    // glitches shorter than the debounce window
    base_s = n_short;
    base_l = n_long;
    repeat (20) begin
      key_in = 1'b0;
      step(10);
      key_in = 1'b1;
      step(20);
    end
    check_eq("s5_short", n_short - base_s, 0);
    check_eq("s5_long", n_long - base_l, 0);
    check_eq("s5_mode", {30'd0, mode}, 0);

    // reset mid-press, key still held at reset release
    clean_short("s6_m1", 1, 1);
    key_in = 1'b0;
    step(100);
    #2 sys_rst_n = 1'b0;
    #1;
    check_eq("s6_async_led", {30'd0, led}, 0);
    check_eq("s6_async_mode", {30'd0, mode}, 0);
    check_eq("s6_async_pulses", {30'd0, press_short, press_long}, 0);
    step(3);
    sys_rst_n = 1'b1;
    step(60);
    key_in = 1'b1;
    expect_mode("s6_held_at_release", 1, 1, 100);
`ifdef KEY_LED_AUTO_OFF_EN
    expect_mode("s6_auto_off", 0, 0, 700);
`else
    step(2000);
    check_eq("s6_mode_holds", {30'd0, mode}, 1);
`endif

    // randomized presses, checked every cycle by the model
    repeat (30) begin
      bounce($urandom_range(0, 15));
      key_in = 1'b0;
      step($urandom_range(3, 320));
      bounce($urandom_range(0, 15));
      key_in = 1'b1;
      step($urandom_range(3, 260));
    end
    step(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_led_mode_ctrl.md
Name: key_led_mode_ctrl

Overview:
- Controller for the board's key/LED pair: synchronises and debounces one raw active-low key, and classifies each press as short or long.
- Sequences a 2-bit LED mode register from those press events and drives two LEDs.
- Owns the LED resource: no other block writes led.
- Sits between the raw key pin and the LED pins.

Parameters:
CNT_DEB, 250, consecutive stable cycles required to accept a key level change (min 2)
CNT_LONG, 1000, cycles the debounced key must stay low to count as a long press (> CNT_DEB)
CNT_BLINK, 50, LED blink half-period in cycles (min 2)
CNT_IDLE, 5000, auto-off timeout in cycles; used only with KEY_LED_AUTO_OFF_EN

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  reset, asynchronous, active-low
key_in  input  1  raw key, active-low, asynchronous to sys_clk
led  output  2  LED drive, active-high
mode  output  2  current mode
press_short  output  1  one-cycle pulse per accepted short press
press_long  output  1  one-cycle pulse when the long threshold is reached

Behaviour:
- Reset state: led=2'b00, mode=2'b00, press_short=0, press_long=0, synchroniser FFs=1, debounced level key_stb=1, FSM=IDLE, all counters=0, blink phase=0.
- Synchroniser:
  - key_in passes through 2 FFs, giving key_sync.
- Debounce:
  - cnt_deb increments while key_sync != key_stb.
  - cnt_deb clears to 0 on any cycle where key_sync == key_stb (a glitch restarts the count).
  - When cnt_deb == CNT_DEB-1 and the mismatch persists: key_stb <= key_sync and cnt_deb <= 0.
  - Net effect: a clean edge on key_in reaches key_stb 2+CNT_DEB cycles later.
- Press FSM states:
  - IDLE: on key_stb 1->0, go to PRESS and clear cnt_press.
  - PRESS: cnt_press increments each cycle.
    - key_stb returns to 1 before cnt_press == CNT_LONG-1: press_short pulses for 1 cycle; go to IDLE.
    - cnt_press == CNT_LONG-1 with key_stb still 0: press_long pulses for 1 cycle; go to HELD.
  - HELD: wait for key_stb==1, then go to IDLE. No short pulse is issued on this release.
  - cnt_press saturates at CNT_LONG-1 and never wraps.
  - press_short and press_long are mutually exclusive per press.
- Mode register (updates the cycle after the pulse):
  - press_short: mode <= mode+1, with 3 wrapping to 0.
  - press_long: mode <= 0.
- Blink timer:
  - cnt_blink counts 0..CNT_BLINK-1.
  - At CNT_BLINK-1 it wraps to 0 and toggles blink.
  - Any mode change clears cnt_blink and blink in the same cycle the mode updates.
- LED map (registered, 1 cycle after mode/blink):
  - mode 0 -> 00
  - mode 1 -> 01 steady
  - mode 2 -> {blink, ~blink} (alternating)
  - mode 3 -> {blink, blink} (together)
- Boundary cases:
  - Reset asserted mid-press: everything returns to reset values immediately; no pulse is issued.
  - A key already held low at reset release is debounced as a new press after 2+CNT_DEB cycles.
  - Bounce shorter than CNT_DEB cycles never changes key_stb.

Optional Feature:
- Macro: KEY_LED_AUTO_OFF_EN.
- Defined:
  - cnt_idle increments while mode != 0 and FSM == IDLE.
  - cnt_idle clears on any press pulse, and whenever mode == 0.
  - At cnt_idle == CNT_IDLE-1: mode <= 0 and cnt_idle <= 0. This is treated as a mode change (the blink timer clears).
- Not defined:
  - No cnt_idle logic exists; mode holds indefinitely.
  - The CNT_IDLE parameter is accepted but unused.

Test Plan:
Use CNT_DEB=20, CNT_LONG=200, CNT_BLINK=10, CNT_IDLE=500 for all scenarios.
1. Reset release, key_in=1 for 1000 cycles -> led=00, mode=0, no pulses.
2. key_in low for 60 cycles with 15-cycle random bounce on both edges, then high -> exactly one press_short; mode 0->1; led=01 one cycle after the mode update.
3. Four clean short presses (60 cycles low, 100 high) -> mode sequence 1,2,3,0. In mode 2, led toggles 01/10 every 10 cycles. In mode 3, led toggles 00/11 every 10 cycles starting from 00.
4. From mode 2, hold key low for 400 cycles -> press_long exactly 2+20+200 cycles after the falling edge (±1), mode=0, led=00, no press_short on release.
5. key_in pulses low for 10 cycles every 30 cycles -> key_stb never changes; no pulses; mode unchanged.
6. Assert sys_rst_n mid-PRESS (cycle 100 of a hold) -> all outputs 0 immediately. With KEY_LED_AUTO_OFF_EN defined and mode=1 left idle, mode returns to 0 after 500 cycles. Without the macro, mode stays 1 for 2000 cycles.
